// File: rtl/conv_sched_pkg.sv
// Shared types and geometry helpers for the 3x3 stride-2 conv filter scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FLUSH,
    STREAM,
    DRAIN,
    NEXT
  } sched_state_e;

  localparam int KERNEL_TAPS  = 9;
  localparam int NUM_CHANNELS = 3;
  localparam int KERNEL_WORDS = KERNEL_TAPS * NUM_CHANNELS;

  function automatic int out_count(input int w, input int h);
    return ((w - 3) / 2 + 1) * ((h - 3) / 2 + 1);
  endfunction

  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// 27-slot weight register file; slot k drives Kernel_Bus bits [32k+31:32k].
module conv_kernel_bank
  import conv_sched_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           we,
  input  logic [4:0]                     slot,
  input  logic [WORD_W-1:0]              wdata,
  output logic [KERNEL_WORDS*WORD_W-1:0] kernel_bus
);

  logic [KERNEL_WORDS-1:0][WORD_W-1:0] bank;

  always_ff @(posedge clk) begin
    if (clr) bank <= '0;
    else if (we && slot < 5'(KERNEL_WORDS)) bank[slot] <= wdata;
  end

  assign kernel_bus = bank;

endmodule

// File: rtl/conv3d_filter_scheduler.sv
// Runs one conv engine over NUM_FILTERS filters: weight load, engine flush,
// full-frame stream, then drain until every output of the filter is written.
module conv3d_filter_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMG_WIDHT     = 299,
  parameter int IMG_HEIGHT    = 299,
  parameter int NUM_FILTERS   = 32,
  parameter int ADDR_WIDTH    = 17,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Start,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Error,
  input  logic [31:0]                    Wgt_Data,
  input  logic                           Wgt_Valid,
  output logic                           Wgt_Ready,
  output logic [32*KERNEL_WORDS-1:0]     Kernel_Bus,
  output logic [$clog2(NUM_FILTERS)-1:0] Filter_Index,
  output logic                           Pix_Rd,
  output logic [ADDR_WIDTH-1:0]          Pix_Addr,
  output logic                           Conv_Rst,
  output logic                           Conv_Valid_In,
  input  logic                           Conv_Valid_Out,
  output logic                           Out_Wr,
  output logic [ADDR_WIDTH-1:0]          Out_Addr
);

  localparam int OUT_COUNT = out_count(IMG_WIDHT, IMG_HEIGHT);
  localparam int NPIX      = npix(IMG_WIDHT, IMG_HEIGHT);
  localparam int FI_W      = $clog2(NUM_FILTERS);
  localparam int OC_W      = $clog2(OUT_COUNT + 1);
  localparam int TO_W      = $clog2(DRAIN_TIMEOUT + 1);

  sched_state_e          state;
  logic [4:0]            slot;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [OC_W-1:0]       out_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  counting;
  logic                  wgt_accept;

  assign Busy       = (state != IDLE);
  assign Wgt_Ready  = (state == LOAD_W);
  assign Conv_Rst   = (state == FLUSH);
  assign Pix_Rd     = (state == STREAM);
  assign Pix_Addr   = pix_cnt;
  assign counting   = (state == STREAM) || (state == DRAIN);
  assign wgt_accept = Wgt_Ready && Wgt_Valid;

  // Writes are combinational on the engine strobe; surplus strobes only flag Error.
  assign Out_Wr   = counting && Conv_Valid_Out && (out_cnt != OC_W'(OUT_COUNT));
  assign Out_Addr = Out_Wr ? ADDR_WIDTH'(out_cnt) : '0;

  conv_kernel_bank u_bank (
    .clk        (clk),
    .clr        (rst),
    .we         (wgt_accept),
    .slot       (slot),
    .wdata      (Wgt_Data),
    .kernel_bus (Kernel_Bus)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      slot          <= '0;
      pix_cnt       <= '0;
      out_cnt       <= '0;
      to_cnt        <= '0;
      Filter_Index  <= '0;
      Done          <= 1'b0;
      Error         <= 1'b0;
      Conv_Valid_In <= 1'b0;
    end else begin
      Done          <= 1'b0;
      Conv_Valid_In <= Pix_Rd;
      if (counting && Conv_Valid_Out) begin
        if (Out_Wr) out_cnt <= out_cnt + 1'b1;
        else        Error   <= 1'b1;
      end
      unique case (state)
        IDLE: if (Start) begin
          state        <= LOAD_W;
          Filter_Index <= '0;
          slot         <= '0;
          Error        <= 1'b0;
        end
        LOAD_W: if (wgt_accept) begin
          if (slot == 5'(KERNEL_WORDS - 1)) begin
            slot  <= '0;
            state <= FLUSH;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        FLUSH: begin
          out_cnt <= '0;
          to_cnt  <= '0;
          pix_cnt <= '0;
          state   <= STREAM;
        end
        STREAM: begin
          if (pix_cnt == ADDR_WIDTH'(NPIX - 1)) begin
            pix_cnt <= '0;
            state   <= DRAIN;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // A full output count wins over a timeout landing on the same cycle.
          if (out_cnt == OC_W'(OUT_COUNT)) begin
            state <= NEXT;
          end else if (to_cnt == TO_W'(DRAIN_TIMEOUT - 1)) begin
            Error <= 1'b1;
            state <= NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (Filter_Index == FI_W'(NUM_FILTERS - 1)) begin
            Done  <= 1'b1;
            state <= IDLE;
          end else begin
            Filter_Index <= Filter_Index + 1'b1;
            slot         <= '0;
            state        <= LOAD_W;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3d_filter_scheduler.sv
// Directed-random bench for conv3d_filter_scheduler on a 7x7 frame, 2 filters.
module tb_conv3d_filter_scheduler;
  localparam int W = 7, H = 7, NF = 2, AW = 6, DT = 16;
  localparam int OC = 9, NP = 49, KW = 27;

  logic clk = 1'b0, rst = 1'b1, Start = 1'b0, Wgt_Valid = 1'b0, Conv_Valid_Out = 1'b0;
  logic [31:0] Wgt_Data = '0;
  logic Busy, Done, Error, Wgt_Ready, Pix_Rd, Conv_Rst, Conv_Valid_In, Out_Wr;
  logic [863:0] Kernel_Bus;
  logic [0:0] Filter_Index;
  logic [AW-1:0] Pix_Addr, Out_Addr;

  conv3d_filter_scheduler #(
    .IMG_WIDHT(W), .IMG_HEIGHT(H), .NUM_FILTERS(NF), .ADDR_WIDTH(AW), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst(rst), .Start(Start), .Busy(Busy), .Done(Done), .Error(Error),
    .Wgt_Data(Wgt_Data), .Wgt_Valid(Wgt_Valid), .Wgt_Ready(Wgt_Ready),
    .Kernel_Bus(Kernel_Bus), .Filter_Index(Filter_Index), .Pix_Rd(Pix_Rd),
    .Pix_Addr(Pix_Addr), .Conv_Rst(Conv_Rst), .Conv_Valid_In(Conv_Valid_In),
    .Conv_Valid_Out(Conv_Valid_Out), .Out_Wr(Out_Wr), .Out_Addr(Out_Addr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [31:0] exp_k [KW];
  int exp_oaddr = 0, pix_seen = 0, wr_f = 0, wr_run = 0, rstp = 0;
  int done_cnt = 0, exp_run_wr = 0, err_idx = 0;
  logic err_load = 1'b0;
  logic prev_rd = 1'b0, prev_rst = 1'b1;
  logic s_busy, s_error, s_wgt_ready, s_conv_rst;
  logic [7:0] s_ctrl;
  logic [12:0] s_addr;
  logic [863:0] s_kbus;
  logic [0:0] s_fidx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_kbus(input string tag, input bit zero);
    logic [863:0] ev;
    ev = '0;
    if (!zero) for (int k = 0; k < KW; k++) ev[32*k +: 32] = exp_k[k];
    checks++;
    assert (s_kbus === ev) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, s_kbus, ev);
    end
  endtask

  // One clock: inputs already driven; sample at negedge, apply rule checks, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    s_busy = Busy; s_error = Error; s_wgt_ready = Wgt_Ready; s_conv_rst = Conv_Rst;
    s_ctrl = {Busy, Done, Error, Wgt_Ready, Pix_Rd, Conv_Rst, Conv_Valid_In, Out_Wr};
    s_addr = {Filter_Index, Pix_Addr, Out_Addr};
    s_kbus = Kernel_Bus; s_fidx = Filter_Index;
    if (Out_Wr) begin
      chk("out_addr", Out_Addr, exp_oaddr);
      exp_oaddr++; wr_f++; wr_run++;
    end
    chk("out_wr_needs_valid", Out_Wr & ~Conv_Valid_Out, 0);
    if (Pix_Rd) begin
      chk("pix_addr", Pix_Addr, pix_seen);
      pix_seen++;
    end
    chk("conv_valid_in_lag", Conv_Valid_In, prev_rd & ~prev_rst);
    if (Conv_Rst) rstp++;
    if (Done) begin
      done_cnt++;
      chk("busy_at_done", Busy, 0);
      chk("writes_at_done", wr_run, exp_run_wr);
    end
    prev_rd = Pix_Rd; prev_rst = rst;
    @(posedge clk); #1;
  endtask

  task automatic run_filter(input int fidx, input int n_emit, input bit late,
                            input bit extra, input bit patterned, input bit abort);
    int acc, emitted, drain_idx, n;
    bit extra_done, in_drain;
    acc = 0; emitted = 0; drain_idx = 0; n = 0; extra_done = 0;
    exp_oaddr = 0; pix_seen = 0; wr_f = 0; rstp = 0; err_idx = 0;
    while (acc < KW && n < 200) begin
      Wgt_Valid = (n % 3 != 2);
      Wgt_Data = patterned ? 32'h3F80_0000 + acc : $urandom;
      Conv_Valid_Out = 1'($urandom_range(0, 1));
      cycle();
      if (Wgt_Valid && s_wgt_ready) begin
        exp_k[acc] = Wgt_Data;
        acc++;
      end
      n++;
    end
    Wgt_Valid = 1'b0; Conv_Valid_Out = 1'b0;
    chk("load_words", acc, KW);
    err_load = s_error;
    cycle();
    chk("ready_after_load", s_wgt_ready, 0);
    chk("conv_rst_flush", s_conv_rst, 1);
    chk("filter_index", s_fidx, fidx);
    chk_kbus("kernel_bus", 0);
    for (int g = 0; g < 300; g++) begin
      in_drain = !Pix_Rd;
      Conv_Valid_Out = 1'b0;
      if (emitted < n_emit && (in_drain || (!late && $urandom_range(0, 4) == 0))) begin
        Conv_Valid_Out = 1'b1; emitted++;
      end else if (extra && !extra_done && emitted == n_emit && in_drain) begin
        Conv_Valid_Out = 1'b1; extra_done = 1;
      end
      Start = Pix_Rd && (Pix_Addr == 10);
      if (abort && Pix_Rd && Pix_Addr == 20) rst = 1'b1;
      cycle();
      Start = 1'b0;
      Conv_Valid_Out = 1'b0;
      if (rst) begin
        rst = 1'b0;
        break;
      end
      if (in_drain) drain_idx++;
      if (in_drain && s_error && err_idx == 0) err_idx = drain_idx;
      if (!s_busy || s_wgt_ready) break;
    end
    if (!abort) begin
      chk("pix_count", pix_seen, NP);
      chk("writes_per_filter", wr_f, n_emit);
      chk("conv_rst_pulses", rstp, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; Conv_Valid_Out = 1'b1;
    cycle();
    chk("reset_ctrl", s_ctrl, 0);
    chk("reset_addr", s_addr, 0);
    chk_kbus("reset_kernel", 1);
    cycle();
    chk("idle_valid_no_error", s_error, 0);
    Conv_Valid_Out = 1'b0;

    // Two normal filters
    wr_run = 0; done_cnt = 0; exp_run_wr = 2 * OC;
    Start = 1'b1; cycle(); Start = 1'b0;
    run_filter(0, OC, 0, 0, 1, 0);
    chk("load_noise_no_err0", err_load, 0);
    chk("err_after_f0", s_error, 0);
    run_filter(1, OC, 0, 0, 0, 0);
    chk("load_noise_no_err1", err_load, 0);
    chk("done_count_a", done_cnt, 1);
    chk("idle_after_a", s_busy, 0);
    chk("err_after_a", s_error, 0);

    // Drain timeout on filter 0, sticky Error
    wr_run = 0; done_cnt = 0; exp_run_wr = 2 * OC - 1;
    Start = 1'b1; cycle(); Start = 1'b0;
    run_filter(0, OC - 1, 0, 0, 0, 0);
    chk("timeout_err_idx", err_idx, DT + 1);
    run_filter(1, OC, 0, 0, 0, 0);
    chk("err_sticky_load", err_load, 1);
    chk("done_count_b", done_cnt, 1);
    repeat (3) cycle();
    chk("err_sticky_idle", s_error, 1);

    // Overrun, then reset mid-stream
    wr_run = 0; done_cnt = 0; exp_run_wr = 0;
    Start = 1'b1; cycle(); Start = 1'b0;
    run_filter(0, OC, 1, 1, 0, 0);
    chk("start_clears_err", err_load, 0);
    chk("overrun_err_idx", err_idx, OC + 2);
    chk("overrun_err_sticky", s_error, 1);
    run_filter(1, OC, 0, 0, 0, 1);
    cycle();
    chk("midrun_reset_ctrl", s_ctrl, 0);
    chk("midrun_reset_addr", s_addr, 0);
    chk_kbus("midrun_reset_kernel", 1);
    repeat (5) cycle();
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", s_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3d_filter_scheduler.md
Name: conv3d_filter_scheduler

Overview:
- Sequences one 3-channel 3x3 stride-2 convolution engine over NUM_FILTERS output filters.
- Per filter: loads 27 FP32 kernel weights from a weight stream into a register bank. Clears the engine's line buffers, then streams the whole 3-channel frame through the engine from an external frame buffer. Counts and addresses the engine's outputs, then moves to the next filter.
- Sits between the weight/frame memories and the conv engine; the output writer consumes Out_Wr/Out_Addr.

Parameters:
- IMG_WIDHT, 299: input frame width in pixels.
- IMG_HEIGHT, 299: input frame height in pixels.
- NUM_FILTERS, 32: output filters per run.
- ADDR_WIDTH, 17: pixel address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDHT*IMG_HEIGHT.
- DRAIN_TIMEOUT, 64: maximum cycles in DRAIN before Error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Start  in  1  begin a run; sampled only in IDLE
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse after the last filter completes
- Error  out  1  sticky; cleared only by rst or by an accepted Start
- Wgt_Data  in  32  FP32 weight word
- Wgt_Valid  in  1  Wgt_Data valid
- Wgt_Ready  out  1  high only in LOAD_W
- Kernel_Bus  out  864  27 x 32 weights; slot k is bits [32k+31:32k]; channel c, tap t is slot 9c+t
- Filter_Index  out  $clog2(NUM_FILTERS)  current filter
- Pix_Rd  out  1  frame buffer read strobe; fixed 1-cycle read latency
- Pix_Addr  out  ADDR_WIDTH  raster address, row-major
- Conv_Rst  out  1  synchronous clear pulse to the engine
- Conv_Valid_In  out  1  Pix_Rd delayed by one cycle; aligned with read data
- Conv_Valid_Out  in  1  engine output strobe
- Out_Wr  out  1  output write strobe
- Out_Addr  out  ADDR_WIDTH  output index within the current filter

Behaviour:
- Derived constants:
  - OUT_W = (IMG_WIDHT-3)/2+1; OUT_H = (IMG_HEIGHT-3)/2+1; OUT_COUNT = OUT_W*OUT_H.
  - NPIX = IMG_WIDHT*IMG_HEIGHT.
  - Defaults give 149x149 = 22201 outputs and 89401 pixels.
- Reset: state IDLE.
  - All outputs 0, including Kernel_Bus, Filter_Index, Out_Addr and Error.
  - The weight slot counter, pixel counter, output counter and timeout counter are cleared.
  - Reset mid-run abandons the run at once; no Done pulse.
- States: IDLE, LOAD_W, FLUSH, STREAM, DRAIN, NEXT.
- IDLE:
  - Start=1 -> LOAD_W next cycle; Filter_Index=0; Error cleared.
  - Start while Busy is ignored.
- LOAD_W:
  - Wgt_Ready=1. Each cycle with Wgt_Valid&Wgt_Ready writes Wgt_Data to slot k, then k++.
  - After slot 26 is written -> FLUSH; Wgt_Ready drops the cycle after the 27th accept.
  - Wgt_Valid gaps simply stall the load.
  - Kernel_Bus slots not yet rewritten keep the previous filter's values.
- FLUSH (exactly 1 cycle):
  - Conv_Rst=1; output counter and timeout counter cleared.
  - -> STREAM.
- STREAM:
  - Pix_Rd=1 every cycle; Pix_Addr steps 0..NPIX-1, one per cycle, no gaps.
  - The cycle issuing NPIX-1 is the last STREAM cycle -> DRAIN.
- DRAIN:
  - Pix_Rd=0.
  - Timeout counter increments each cycle.
  - Leave when the output count reaches OUT_COUNT -> NEXT.
  - Timeout counter reaching DRAIN_TIMEOUT sets Error and forces NEXT.
- Output counting (STREAM and DRAIN only):
  - Conv_Valid_Out=1 with count < OUT_COUNT gives Out_Wr=1 and Out_Addr=count in the same cycle (combinational), then count++.
  - Conv_Valid_Out while count==OUT_COUNT sets Error; no Out_Wr.
  - Conv_Valid_Out in IDLE, LOAD_W, FLUSH or NEXT is ignored; no Out_Wr, no Error.
- NEXT (1 cycle):
  - Filter_Index==NUM_FILTERS-1 -> Done=1 for one cycle; -> IDLE.
  - Otherwise Filter_Index++ and k=0; -> LOAD_W.
- Conv_Valid_In: registered copy of Pix_Rd (latency 1). It is therefore still high in the first DRAIN cycle.
- Counter widths are sized so none wraps; no counter may exceed its terminal value.

Decomposition:
- Shared package conv_sched_pkg holds:
  - state enum (IDLE..NEXT, 3-bit);
  - KERNEL_TAPS=9, NUM_CHANNELS=3, KERNEL_WORDS=27;
  - functions for OUT_COUNT and NPIX.
- One natural sub-module: conv_kernel_bank, a 27x32 register file with write enable, 5-bit slot index, synchronous clear, and the flattened Kernel_Bus output.

Test Plan (IMG_WIDHT=IMG_HEIGHT=7, NUM_FILTERS=2, DRAIN_TIMEOUT=16; OUT_COUNT=9, NPIX=49):
- Weight load: Start, then 27 words 0x3F800000+k with Wgt_Valid gaps on every third cycle -> slot k holds 0x3F800000+k; Wgt_Ready low in the cycle after the 27th accept; Conv_Rst high for exactly 1 cycle.
- Streaming: model engine emits 9 Conv_Valid_Out pulses -> Pix_Addr runs 0..48 on 49 consecutive cycles; Conv_Valid_In lags Pix_Rd by 1; Out_Addr goes 0..8.
- Full run: two filters -> Filter_Index 0 then 1; second weight load overwrites all slots; a single Done pulse after the 18th Out_Wr; Busy falls with Done.
- Timeout: model emits only 8 outputs -> Error=1 exactly 16 cycles into DRAIN; scheduler still advances; Error stays high until the next accepted Start.
- Overrun: a 10th Conv_Valid_Out in DRAIN -> Error=1 and no 10th Out_Wr; Conv_Valid_Out pulses during LOAD_W -> no Out_Wr, no Error.
- Reset and Start: rst asserted mid-STREAM at address 20 -> next cycle IDLE, all outputs 0, no Done; Start pulsed while Busy -> ignored.
